// File: rtl/fetch_seq.sv
// Variable-length instruction fetch over a multiplexed address/data bus.
// Each word costs one address phase plus a wait phase; completed instructions are handed to decode via valid/ready.
module fetch_seq #(
  parameter int          W         = 8,
  parameter int          WORDS_MAX = 3,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   run,
  input  logic                   jmp_valid,
  input  logic [W-1:0]           jmp_addr,
  output logic [W-1:0]           bus_out,
  output logic                   bus_oe,
  output logic                   mem_rd,
  input  logic                   mem_rdy,
  input  logic [W-1:0]           bus_in,
  output logic [W*WORDS_MAX-1:0] instr,
  output logic [$clog2(WORDS_MAX+1)-1:0] instr_len,
  output logic [W-1:0]           instr_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [W-1:0]           pc,
  output logic                   busy
);

  localparam int LB = $clog2(WORDS_MAX);
  localparam int LW = $clog2(WORDS_MAX+1);

  typedef enum logic [1:0] {IDLE, ADDR, WAIT, HOLD} state_t;

  state_t                 state_q, state_d;
  logic [W-1:0]           pc_q, pc_d;
  logic [LW-1:0]          cnt_q, cnt_d;
  logic [W*WORDS_MAX-1:0] instr_q, instr_d;
  logic [LW-1:0]          len_q, len_d;
  logic [W-1:0]           ipc_q, ipc_d;
  logic                   valid_q, valid_d;
  logic                   jpend_q, jpend_d;
  logic [W-1:0]           jaddr_q, jaddr_d;

  logic [LB:0]            raw_len;
  logic [LW-1:0]          first_len;
  logic [LW-1:0]          cur_len;
  logic                   last_word;
  logic                   jmp_any;
  logic [W-1:0]           jmp_tgt;
  logic [WORDS_MAX-1:0]   word_sel;

  genvar gi;
  generate
    for (gi = 0; gi < WORDS_MAX; gi++) begin : g_sel
      assign word_sel[gi] = (cnt_q == LW'(gi));
    end
  endgenerate

  // Length lives in the top LB bits of the first word, saturated to WORDS_MAX.
  assign raw_len   = {1'b0, bus_in[W-1 -: LB]} + (LB+1)'(1);
  assign first_len = (raw_len > (LB+1)'(WORDS_MAX)) ? LW'(WORDS_MAX) : LW'(raw_len);
  assign cur_len   = word_sel[0] ? first_len : len_q;
  assign last_word = ((cnt_q + LW'(1)) == cur_len);

  // A jump arriving on the completing cycle counts as pending too.
  assign jmp_any = jpend_q | jmp_valid;
  assign jmp_tgt = jmp_valid ? jmp_addr : jaddr_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    len_d   = len_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    jpend_d = jpend_q;
    jaddr_d = jaddr_q;
    case (state_q)
      IDLE: begin
        if (jmp_valid) pc_d = jmp_addr;
        if (run) state_d = ADDR;
      end
      ADDR: begin
        pc_d    = pc_q + W'(1);
        state_d = WAIT;
        if (jmp_valid) begin
          jpend_d = 1'b1;
          jaddr_d = jmp_addr;
        end
      end
      WAIT: begin
        if (jmp_valid) begin
          jpend_d = 1'b1;
          jaddr_d = jmp_addr;
        end
        if (mem_rdy) begin
          if (jmp_any) begin
            pc_d    = jmp_tgt;
            cnt_d   = '0;
            jpend_d = 1'b0;
            state_d = run ? ADDR : IDLE;
          end else begin
            for (int k = 0; k < WORDS_MAX; k++) begin
              if (word_sel[k])      instr_d[k*W +: W] = bus_in;
              else if (word_sel[0]) instr_d[k*W +: W] = '0;
            end
            if (word_sel[0]) begin
              ipc_d = pc_q - W'(1);
              len_d = first_len;
            end
            if (last_word) begin
              valid_d = 1'b1;
              state_d = HOLD;
            end else begin
              cnt_d   = cnt_q + LW'(1);
              state_d = ADDR;
            end
          end
        end
      end
      HOLD: begin
        if (jmp_valid || instr_ready) begin
          valid_d = 1'b0;
          cnt_d   = '0;
          state_d = run ? ADDR : IDLE;
          if (jmp_valid) pc_d = jmp_addr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      pc_q    <= W'(RESET_PC);
      cnt_q   <= '0;
      instr_q <= '0;
      len_q   <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
      jpend_q <= 1'b0;
      jaddr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      len_q   <= len_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
      jpend_q <= jpend_d;
      jaddr_q <= jaddr_d;
    end
  end

  assign bus_oe      = (state_q == ADDR);
  assign mem_rd      = (state_q == ADDR);
  assign bus_out     = (state_q == ADDR) ? pc_q : '0;
  assign busy        = (state_q != IDLE);
  assign instr       = instr_q;
  assign instr_len   = len_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
- Parametrised successor to the AY8 single-word fetch unit.
- Fetches variable-length instructions (1..WORDS_MAX words) over the shared multiplexed address/data memory bus, where address and data use the same bus in successive phases.
- Supports memory wait states, PC load (jump) with abort of the in-flight instruction, and a valid/ready handoff to the decode stage.
- Sits between the memory interface and decode in the core.

Parameters:
W, 8, address and data word width (PC width = bus width = W)
WORDS_MAX, 3, maximum instruction length in words (2..4)
RESET_PC, 0, PC value after reset

Ports:
CLK  input  1  clock; all state changes on rising edge
RST  input  1  synchronous, active-high reset
run  input  1  level; fetching proceeds while high
jmp_valid  input  1  load PC this cycle
jmp_addr  input  W  new PC
bus_out  output  W  value driven onto shared bus (address phase)
bus_oe  output  1  bus_out enable; top level tri-states the bus when low
mem_rd  output  1  read strobe, one cycle per word, coincident with bus_oe
mem_rdy  input  1  memory data valid on bus_in this cycle
bus_in  input  W  shared bus read-back
instr  output  W*WORDS_MAX  fetched words; word k at bits [k*W +: W]; unused words zero
instr_len  output  clog2(WORDS_MAX+1)  words in instr (1..WORDS_MAX)
instr_pc  output  W  address of the instruction's first word
instr_valid  output  1  instruction available to decode
instr_ready  input  1  decode accepts when valid&ready
pc  output  W  address of the next word to fetch
busy  output  1  state != IDLE

Behaviour:
- Reset (RST high at CLK edge, any state):
  - pc=RESET_PC, state=IDLE.
  - All outputs and internal registers other than pc reset to 0: instr, instr_len, instr_pc, instr_valid, bus_oe, mem_rd, busy; word counter, jump-pending flag.
  - Reset overrides jmp_valid and abandons any outstanding memory transaction.
- States: IDLE, ADDR, WAIT, HOLD.
- IDLE: run=1 -> ADDR next cycle.
- ADDR (exactly one cycle): bus_out=pc, bus_oe=1, mem_rd=1; pc<=pc+1 mod 2^W; -> WAIT. In all other states bus_oe=0, mem_rd=0.
- WAIT: hold until mem_rdy=1 (unbounded wait states). On mem_rdy, bus_in is stored as word[cnt].
  - cnt=0 (first word): instr_pc<=pc-1; total length = 1 + bus_in[W-1 -: LB], LB=clog2(WORDS_MAX), saturated to WORDS_MAX.
  - If more words remain: cnt++, -> ADDR.
  - Otherwise: instr_valid<=1, -> HOLD.
- HOLD: instr_valid=1; instr, instr_len, instr_pc stable.
  - On instr_valid&instr_ready: instr_valid<=0, cnt<=0; -> ADDR if run=1, else IDLE.
  - run=0 never drops a valid instruction.
- Throughput: 2 cycles per word with zero wait states; a 1-word instruction is valid 2 cycles after ADDR entry.
- Jump, IDLE or HOLD: pc<=jmp_addr next cycle; in HOLD, instr_valid<=0 without handshake; then ADDR if run=1, else IDLE.
- Jump, ADDR or WAIT: jmp_addr is latched with a pending flag.
  - The current word completes (mem_rdy still awaited); its data is discarded.
  - Then pc<=pending addr, cnt<=0, -> ADDR if run=1, else IDLE. No instr_valid is produced for the aborted instruction.
  - A later jmp_valid before completion overwrites the pending address.
- Jump coincident with accept in HOLD: the accept completes and the jump wins for the next PC.
- PC wraps 2^W-1 -> 0 silently, including mid-instruction.
- run deasserted in ADDR/WAIT: the current instruction still completes to HOLD.

Test Plan:
- W=8, WORDS_MAX=3, reset then run=1, mem returns 0x05 at addr 0 with mem_rdy immediate, instr_ready=1 -> bus_out=0x00 with mem_rd; instr_valid 2 cycles later, instr=0x000005, instr_len=1, instr_pc=0; pc=1.
- Mem[1]=0x80 (len 3), mem[2]=0xAA, mem[3]=0xBB -> three ADDR phases on 1,2,3; instr=0xBBAA80, instr_len=3, instr_pc=1; pc=4.
- First word 0xC0 (field=3, WORDS_MAX=3) -> instr_len saturates to 3, exactly 3 reads.
- 3 wait-state cycles on a word (mem_rdy low) -> bus_oe=0 throughout WAIT, no extra mem_rd, captured value is the one present when mem_rdy=1.
- jmp_valid with jmp_addr=0x40 during WAIT of word 2 of a 3-word instr -> word completes, no instr_valid, next ADDR drives 0x40.
- instr_ready=0 for 5 cycles in HOLD -> outputs stable, no bus activity; pc=0xFF 1-word fetch -> pc becomes 0x00; RST mid-WAIT -> all outputs 0, pc=RESET_PC next cycle.
